// File: rtl/clk_div_pkg.sv
// Shared widths and defaults for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF        = 9;
    localparam int unsigned DEFAULT_HALF_DEF = 100;
    localparam int unsigned CH_IDX_W         = 4;

    typedef logic [CNT_W_DEF-1:0] half_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, square-wave output, toggle tick and
// a single-entry pending half-period that commits on the next wrap.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_acc,
    input  logic [CNT_W-1:0] i_half,
    output logic             o_pending,
    output logic             o_div_out,
    output logic             o_div_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend_half;
    logic             r_pending;
    logic             r_div_out;
    logic             r_div_tick;
    logic             w_wrap;
    logic             w_commit;

    assign w_wrap   = i_en & ~i_sync & (r_cnt == r_half);
    // A disabled channel has no boundary to wait for, so it commits immediately.
    assign w_commit = r_pending & (~i_en | i_sync | w_wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_out  <= 1'b0;
            r_div_tick <= 1'b0;
        end else if (~i_en | i_sync) begin
            r_cnt      <= '0;
            r_div_out  <= 1'b0;
            r_div_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt      <= '0;
            r_div_out  <= ~r_div_out;
            r_div_tick <= 1'b1;
        end else begin
            r_cnt      <= CNT_W'(r_cnt + 1'b1);
            r_div_tick <= 1'b0;
        end
    end

    // Accept only arrives while nothing is pending, so accept and commit never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_half      <= CNT_W'(DEFAULT_HALF);
            r_pend_half <= '0;
            r_pending   <= 1'b0;
        end else if (i_acc) begin
            r_pend_half <= i_half;
            r_pending   <= 1'b1;
        end else if (w_commit) begin
            r_half      <= r_pend_half;
            r_pending   <= 1'b0;
        end
    end

    assign o_pending  = r_pending;
    assign o_div_out  = r_div_out;
    assign o_div_tick = r_div_tick;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with valid/ready half-period updates.
// Optional CLKDIV_SYNC_EN adds sync_in to realign all enabled channel phases.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_in,
`endif
    input  logic [N_CH-1:0]     ch_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_chan,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic                cfg_err,
    output logic [N_CH-1:0]     div_out,
    output logic [N_CH-1:0]     div_tick
);

    localparam int unsigned MAX_CH = 1 << CH_IDX_W;

    logic              w_sync;
    logic              w_idx_ok;
    logic [N_CH-1:0]   w_pending;
    logic [N_CH-1:0]   w_acc;
    logic [MAX_CH-1:0] w_pend_ext;
    logic              r_cfg_err;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    assign w_idx_ok = (32'(cfg_chan) < N_CH);

    // Zero-extend pending flags so any 4-bit index selects a defined bit.
    always_comb begin
        w_pend_ext             = '0;
        w_pend_ext[N_CH-1:0]   = w_pending;
    end

    assign cfg_ready = w_idx_ok ? ~w_pend_ext[cfg_chan] : 1'b1;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_acc[g] = cfg_valid & cfg_ready & w_idx_ok & (cfg_chan == CH_IDX_W'(g));

        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_en       (ch_en[g]),
            .i_sync     (w_sync),
            .i_acc      (w_acc[g]),
            .i_half     (cfg_half),
            .o_pending  (w_pending[g]),
            .o_div_out  (div_out[g]),
            .o_div_tick (div_tick[g])
        );
    end

    // Out-of-range requests are always accepted and flagged one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_valid & ~w_idx_ok;
        end
    end

    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: toggle-schedule model plus directed scenarios.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = CNT_W_DEF;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             sync_in   = 1'b0;
    logic [N_CH-1:0]  ch_en     = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [3:0]       cfg_chan  = '0;
    half_t            cfg_half  = '0;
    logic             cfg_err;
    logic [N_CH-1:0]  div_out;
    logic [N_CH-1:0]  div_tick;

    always #5 clk = ~clk;

    clk_div_multi #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_half  (cfg_half),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .div_tick  (div_tick)
    );

    // Model: each running channel keeps the absolute edge number of its next toggle.
    int unsigned     t = 0;
    bit [N_CH-1:0]   m_out;
    bit [N_CH-1:0]   m_tick;
    bit [N_CH-1:0]   m_run;
    bit [N_CH-1:0]   m_pend;
    bit              m_err;
    int unsigned     m_half      [N_CH];
    int unsigned     m_pend_half [N_CH];
    int unsigned     m_next      [N_CH];

    function automatic bit model_ready(input logic [3:0] ch);
        if (32'(ch) >= N_CH) return 1'b1;
        return !m_pend[ch[1:0]];
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit idx_ok;
        t++;
        idx_ok = (32'(cfg_chan) < N_CH);
        if (rst) begin
            m_out  = '0;
            m_tick = '0;
            m_run  = '0;
            m_pend = '0;
            m_err  = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                m_half[c]      = 100;
                m_pend_half[c] = 0;
                m_next[c]      = 0;
            end
        end else begin
            m_err = cfg_valid && !idx_ok;
            for (int c = 0; c < N_CH; c++) begin
                acc       = cfg_valid && idx_ok && (32'(cfg_chan) == 32'(c)) && !m_pend[c];
                m_tick[c] = 1'b0;
                if (!ch_en[c]) begin
                    m_run[c] = 1'b0;
                    m_out[c] = 1'b0;
                    if (m_pend[c]) begin m_half[c] = m_pend_half[c]; m_pend[c] = 1'b0; end
                end else if (sync_in) begin
                    m_run[c] = 1'b1;
                    m_out[c] = 1'b0;
                    if (m_pend[c]) begin m_half[c] = m_pend_half[c]; m_pend[c] = 1'b0; end
                    m_next[c] = t + 1 + m_half[c];
                end else begin
                    if (!m_run[c]) begin
                        m_run[c]  = 1'b1;
                        m_next[c] = t + m_half[c];
                    end
                    if (t == m_next[c]) begin
                        m_out[c]  = !m_out[c];
                        m_tick[c] = 1'b1;
                        if (m_pend[c]) begin m_half[c] = m_pend_half[c]; m_pend[c] = 1'b0; end
                        m_next[c] = t + 1 + m_half[c];
                    end
                end
                if (acc) begin
                    m_pend[c]      = 1'b1;
                    m_pend_half[c] = 32'(cfg_half);
                end
            end
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        @(negedge clk);
        cyc++;
        check("div_out",   32'(div_out),   32'(m_out));
        check("div_tick",  32'(div_tick),  32'(m_tick));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
        check("cfg_ready", 32'(cfg_ready), 32'(model_ready(cfg_chan)));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_tick(input logic [1:0] ch, input int max_n, output int n);
        n = -1;
        for (int k = 1; k <= max_n; k++) begin
            step();
            if (div_tick[ch] === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic send_cfg(input logic [3:0] ch, input half_t h, input int max_wait);
        bit done;
        done      = 1'b0;
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_half  = h;
        for (int k = 0; k < max_wait && !done; k++) begin
            #1;
            done = model_ready(ch);
            check("cfg_ready_hs", 32'(cfg_ready), 32'(done));
            step();
        end
        cfg_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cfg_timeout: chan=%0d not accepted within %0d cycles", ch, max_wait);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  c2;
        int  f0;
        int  f1;
        bit  done;

        // Reset state
        rst = 1'b1;
        run(2);
        check("rst_div_out",  32'(div_out),  32'd0);
        check("rst_div_tick", 32'(div_tick), 32'd0);
        check("rst_cfg_err",  32'(cfg_err),  32'd0);
        rst = 1'b0;

        // Default half of 100 on ch0: toggles 101 cycles apart
        ch_en = 4'b0001;
        wait_tick(2'd0, 150, n);
        check("t1_tick101", 32'(n), 32'd101);
        check("t1_out_hi", 32'(div_out[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(2'd0, 150, n);
            check("t1_tick_interval", 32'(n), 32'd101);
        end
        check("t1_out_lo", 32'(div_out[0]), 32'd0);
        check("t1_others_idle", 32'(div_out[3:1]), 32'd0);

        // ch1 -> half=0 mid-interval: old interval finishes, then clk/2
        ch_en = 4'b0011;
        run(30);
        send_cfg(4'd1, half_t'(0), 5);
        wait_tick(2'd1, 200, n);
        check("t2_old_interval", 32'(n), 32'd70);
        for (int i = 0; i < 4; i++) begin
            wait_tick(2'd1, 3, n);
            check("t2_div2", 32'(n), 32'd1);
        end

        // ch2 -> half=3 mid-count, then a second request held until commit
        ch_en = 4'b0111;
        c2    = int'(cyc);
        run(10);
        send_cfg(4'd2, half_t'(3), 5);
        step();
        check("t3_ready_low", 32'(cfg_ready), 32'd0);
        send_cfg(4'd2, half_t'(5), 200);
        check("t3_second_accept", 32'(int'(cyc) - c2), 32'd102);
        wait_tick(2'd2, 20, n);
        check("t3_interval4", 32'(n), 32'd3);
        wait_tick(2'd2, 20, n);
        check("t3_interval6a", 32'(n), 32'd6);
        wait_tick(2'd2, 20, n);
        check("t3_interval6b", 32'(n), 32'd6);

        // Out-of-range channel index
        cfg_chan = 4'd9;
        step();
        check("t4_ready_bad_idx", 32'(cfg_ready), 32'd1);
        send_cfg(4'd9, half_t'(7), 5);
        check("t4_err_pulse", 32'(cfg_err), 32'd1);
        step();
        check("t4_err_clear", 32'(cfg_err), 32'd0);

        // Reset with ch0 pending and cnt=57
        ch_en = 4'b0110;
        step();
        ch_en = 4'b0111;
        run(50);
        send_cfg(4'd0, half_t'(20), 5);
        run(6);
        check("t5_pending_before", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_out",   32'(div_out),   32'd0);
        check("t5_rst_tick",  32'(div_tick),  32'd0);
        check("t5_rst_ready", 32'(cfg_ready), 32'd1);
        wait_tick(2'd0, 150, n);
        check("t5_half_default", 32'(n), 32'd101);
        wait_tick(2'd0, 150, n);
        check("t5_no_stale_commit", 32'(n), 32'd101);

`ifdef CLKDIV_SYNC_EN
        // Phase realignment with sync_in
        send_cfg(4'd0, half_t'(4), 5);
        send_cfg(4'd1, half_t'(9), 5);
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            done = model_ready(4'd0) && model_ready(4'd1);
        end
        check("t6_committed_ch0", 32'(cfg_ready | !done), 32'd1);
        run(3);
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("t6_sync_out", 32'(div_out), 32'd0);
        f0 = -1;
        f1 = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (div_tick[0] === 1'b1 && f0 < 0) f0 = k;
            if (div_tick[1] === 1'b1 && f1 < 0) f1 = k;
        end
        check("t6_ch0_after_sync", 32'(f0), 32'd5);
        check("t6_ch1_after_sync", 32'(f1), 32'd10);
`else
        done = 1'b0;
        f0   = 0;
        f1   = 0;
        if (done) run(f0 + f1);
`endif

        ch_en = '0;
        run(3);
        check("end_idle_out", 32'(div_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
